// File: rtl/alu_operand_loader.sv
// Purpose: debounce four active-low keys, capture sign-extended switch operands, issue them with an opcode to the ALU.
// Latency: a key press becomes an internal event DEBOUNCE_CYCLES+2 edges after the first synchronizer sample; the FSM acts on the following edge.
// Backpressure: none; events that lose priority, or that arrive during the ISSUE cycle, are dropped rather than queued.
module alu_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DATA_W          = 32,
  parameter int OP_W            = 4
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic [3:0]        KEY,
  input  logic [17:0]       SW,
  output logic [DATA_W-1:0] alu_input1,
  output logic [DATA_W-1:0] alu_input2,
  output logic [OP_W-1:0]   alu_op,
  output logic              issue_valid,
  output logic              error,
  output logic [OP_W-1:0]   pending_op,
  output logic [2:0]        state_code
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_EMPTY  = 3'd0,
    ST_A_ONLY = 3'd1,
    ST_B_ONLY = 3'd2,
    ST_BOTH   = 3'd3,
    ST_ISSUE  = 3'd4
  } state_t;

  logic [3:0]       sync1_q, sync2_q, deb_q, press_q;
  logic [CNT_W-1:0] cnt_q [4];
  state_t           state_q;
  logic [DATA_W-1:0] opa_q, opb_q;
  logic [DATA_W-1:0] operand_d;
  logic             unused_sw;

  // SW[17] has no function on this board.
  assign unused_sw = SW[17];

  // Switch value sign-extended from bit 16 to the full operand width.
  assign operand_d = {{(DATA_W-17){SW[16]}}, SW[16:0]};

  assign state_code = state_q;

  // Two-flop synchronizer plus per-key stability counter; a press is a debounced 1->0 flip.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      deb_q   <= 4'hF;
      press_q <= 4'h0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= KEY;
      sync2_q <= sync1_q;
      for (int i = 0; i < 4; i++) begin
        press_q[i] <= 1'b0;
        if (sync2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          cnt_q[i]   <= '0;
          deb_q[i]   <= sync2_q[i];
          // Only a released->pressed flip is an event; releases are silent.
          press_q[i] <= deb_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Operand/opcode FSM with registered outputs; execute > load A > load B > next op.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q     <= ST_EMPTY;
      opa_q       <= '0;
      opb_q       <= '0;
      pending_op  <= '0;
      alu_input1  <= '0;
      alu_input2  <= '0;
      alu_op      <= '0;
      issue_valid <= 1'b0;
      error       <= 1'b0;
    end else begin
      issue_valid <= 1'b0;
      error       <= 1'b0;
      if (state_q == ST_ISSUE) begin
        // The issue cycle itself ignores every key event.
        state_q <= ST_BOTH;
      end else if (press_q[3]) begin
        if (state_q == ST_BOTH) begin
          // Outputs are loaded together with the move into ISSUE so that
          // issue_valid and the new alu_* values appear in the ISSUE cycle.
          state_q     <= ST_ISSUE;
          alu_input1  <= opa_q;
          alu_input2  <= opb_q;
          alu_op      <= pending_op;
          issue_valid <= 1'b1;
        end else begin
          error <= 1'b1;
        end
      end else if (press_q[0]) begin
        opa_q <= operand_d;
        if (state_q == ST_EMPTY)       state_q <= ST_A_ONLY;
        else if (state_q == ST_B_ONLY) state_q <= ST_BOTH;
      end else if (press_q[1]) begin
        opb_q <= operand_d;
        if (state_q == ST_EMPTY)       state_q <= ST_B_ONLY;
        else if (state_q == ST_A_ONLY) state_q <= ST_BOTH;
      end else if (press_q[2]) begin
        pending_op <= pending_op + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with a short debounce window.
// Latency: events observed via state/pulses a fixed number of edges after a key change.
// Backpressure: not applicable; keys are held long enough to settle both edges.
module tb_alu_operand_loader;

  logic        clk;
  logic        RESET;
  logic [3:0]  KEY;
  logic [17:0] SW;
  logic [31:0] alu_input1, alu_input2;
  logic [3:0]  alu_op, pending_op;
  logic        issue_valid, error;
  logic [2:0]  state_code;

  int n_assert = 0;
  int n_fail   = 0;
  int iv_cnt, er_cnt;
  logic [2:0] st_at_iv;
  logic found;

  alu_operand_loader #(.DEBOUNCE_CYCLES(4), .DATA_W(32), .OP_W(4)) dut (
    .CLOCK_50   (clk),
    .RESET      (RESET),
    .KEY        (KEY),
    .SW         (SW),
    .alu_input1 (alu_input1),
    .alu_input2 (alu_input2),
    .alu_op     (alu_op),
    .issue_valid(issue_valid),
    .error      (error),
    .pending_op (pending_op),
    .state_code (state_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sample one cycle at the falling edge, tallying pulses.
  task automatic step();
    @(negedge clk);
    if (issue_valid) begin
      iv_cnt++;
      st_at_iv = state_code;
    end
    if (error) er_cnt++;
  endtask

  // Hold the keys in mask m long enough to debounce, then release and let the release settle.
  task automatic press(input logic [3:0] m, input logic [16:0] sw);
    @(negedge clk);
    SW = {1'b0, sw};
    KEY = ~m;
    iv_cnt = 0;
    er_cnt = 0;
    st_at_iv = 3'd7;
    repeat (12) step();
    KEY = 4'hF;
    repeat (12) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    RESET = 1'b1;
    @(negedge clk);
    RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b0;
    KEY   = 4'hF;
    SW    = '0;
    do_reset();

    // Reset state
    chk("rst_state", state_code, 0);
    chk("rst_in1", alu_input1, 0);
    chk("rst_in2", alu_input2, 0);
    chk("rst_op", alu_op, 0);
    chk("rst_pend", pending_op, 0);
    chk("rst_iv", issue_valid, 0);
    chk("rst_err", error, 0);

    // 1a: KEY[0] held; first sampled at edge 1, acted on at edge 7
    @(negedge clk);
    SW  = 18'h1FFFF;
    KEY = 4'b1110;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk);
      #1;
      if (e == 6) chk("deb_edge6_state", state_code, 0);
      if (e == 7) chk("deb_edge7_state", state_code, 1);
    end
    repeat (10) @(negedge clk);
    KEY = 4'hF;
    repeat (12) @(negedge clk);
    chk("deb_single_event", state_code, 1);

    // 1b: 3-cycle glitch on KEY[1] must not load B
    KEY = 4'b1101;
    repeat (3) @(negedge clk);
    KEY = 4'hF;
    repeat (12) @(negedge clk);
    chk("glitch_state", state_code, 1);

    // 2: normal issue
    press(4'b0001, 17'h00005);
    chk("n_loadA_state", state_code, 1);
    press(4'b0010, 17'h10003);
    chk("n_loadB_state", state_code, 3);
    press(4'b0100, 17'h0);
    press(4'b0100, 17'h0);
    press(4'b0100, 17'h0);
    chk("n_pend", pending_op, 3);
    press(4'b1000, 17'h0);
    chk("n_iv_cnt", iv_cnt, 1);
    chk("n_err_cnt", er_cnt, 0);
    chk("n_state_at_iv", st_at_iv, 4);
    chk("n_in1", alu_input1, 32'h00000005);
    chk("n_in2", alu_input2, 32'hFFFF0003);
    chk("n_op", alu_op, 3);
    chk("n_state_after", state_code, 3);

    // 3: error path from EMPTY and A_ONLY
    do_reset();
    press(4'b1000, 17'h0);
    chk("e0_err_cnt", er_cnt, 1);
    chk("e0_iv_cnt", iv_cnt, 0);
    chk("e0_state", state_code, 0);
    press(4'b0001, 17'h00002);
    chk("e1_loadA", state_code, 1);
    press(4'b1000, 17'h0);
    chk("e1_err_cnt", er_cnt, 1);
    chk("e1_iv_cnt", iv_cnt, 0);
    chk("e1_state", state_code, 1);
    chk("e1_in1", alu_input1, 0);
    chk("e1_in2", alu_input2, 0);

    // 4: opcode wraps 15 -> 0
    do_reset();
    for (int i = 0; i < 17; i++) press(4'b0100, 17'h0);
    chk("wrap_pend", pending_op, 1);

    // 5: simultaneous execute + load A in BOTH
    do_reset();
    press(4'b0001, 17'h00005);
    press(4'b0010, 17'h10003);
    press(4'b1001, 17'h00007);
    chk("sim_iv_cnt", iv_cnt, 1);
    chk("sim_in1_old", alu_input1, 32'h5);
    chk("sim_in2", alu_input2, 32'hFFFF0003);
    chk("sim_op", alu_op, 0);
    press(4'b1000, 17'h0);
    chk("sim_A_dropped", alu_input1, 32'h5);

    // 6: reset during ISSUE with KEY[3] held throughout
    @(negedge clk);
    KEY = 4'b0111;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (issue_valid) found = 1'b1;
    end
    chk("r_issue_seen", found, 1);
    chk("r_issue_state", state_code, 4);
    RESET = 1'b1;
    @(negedge clk);
    chk("r_state", state_code, 0);
    chk("r_iv", issue_valid, 0);
    chk("r_in1", alu_input1, 0);
    chk("r_in2", alu_input2, 0);
    chk("r_op", alu_op, 0);
    chk("r_pend", pending_op, 0);
    RESET = 1'b0;
    iv_cnt = 0;
    er_cnt = 0;
    repeat (15) step();
    chk("r_held_err", er_cnt, 1);
    chk("r_held_iv", iv_cnt, 0);
    KEY = 4'hF;
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
